// File: rtl/uart_txrx.sv
// 8N1 UART transmitter and receiver sharing one clock.
// Define UART_FRAME_ERR_EN to flag and drop frames whose stop bit reads 0.
module uart_txrx #(
  parameter int CLOCKS_PER_PULSE = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_en,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  input  logic       ready_clr,
  output logic       ready,
  output logic [7:0] data_out
`ifdef UART_FRAME_ERR_EN
  ,
  output logic       frame_err
`endif
);

  localparam int CW = $clog2(CLOCKS_PER_PULSE);
  localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CW-1:0] HALF = CW'(CLOCKS_PER_PULSE / 2 - 1);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
`ifdef UART_FRAME_ERR_EN
  localparam logic [2:0] RX_WAIT  = 3'd4;
`endif

  logic [1:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_data_q, tx_data_d;

  logic [2:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          ready_q, ready_d;
  logic          rx_done;
`ifdef UART_FRAME_ERR_EN
  logic          frame_err_q, frame_err_d;
`endif

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_data_d  = tx_data_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (!data_en) begin
          tx_data_d  = data_in;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_cnt_q == LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_cnt_q == LAST) begin
          tx_cnt_d = '0;
          tx_bit_d = tx_bit_q + 1'b1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end
        end
      end
      TX_STOP: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_cnt_q == LAST) begin
          tx_cnt_d = '0;
          // a held request chains the next frame with no idle cycle
          if (!data_en) begin
            tx_data_d  = data_in;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_data_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_comb begin
    tx = 1'b1;
    if (tx_state_q == TX_START) begin
      tx = 1'b0;
    end else if (tx_state_q == TX_DATA) begin
      tx = tx_data_q[tx_bit_q];
    end
  end

  assign tx_busy = (tx_state_q != TX_IDLE);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    data_out_d = data_out_q;
    rx_done    = 1'b0;
`ifdef UART_FRAME_ERR_EN
    frame_err_d = 1'b0;
`endif
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rx) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
`ifdef UART_FRAME_ERR_EN
          if (!rx) begin
            frame_err_d = 1'b1;
            rx_state_d  = RX_WAIT;
          end else begin
            data_out_d = rx_shift_q;
            rx_done    = 1'b1;
          end
`else
          data_out_d = rx_shift_q;
          rx_done    = 1'b1;
`endif
        end
      end
`ifdef UART_FRAME_ERR_EN
      RX_WAIT: begin
        if (rx) begin
          rx_state_d = RX_IDLE;
        end
      end
`endif
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // a completing byte overrides a same-cycle clear
  always_comb begin
    ready_d = ready_q;
    if (!ready_clr) begin
      ready_d = 1'b0;
    end
    if (rx_done) begin
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
    end
  end

`ifdef UART_FRAME_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`endif

  assign ready    = ready_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_uart_txrx.sv
// Directed + random bench for uart_txrx at 4 clocks per bit.
// Expected line levels come from an arithmetic frame model.
module tb_uart_txrx;

  localparam int CPP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_en;
  logic [7:0] data_in;
  logic       tx;
  logic       tx_busy;
  logic       rx;
  logic       rx_drv;
  logic       loop;
  logic       ready_clr;
  logic       ready;
  logic [7:0] data_out;
`ifdef UART_FRAME_ERR_EN
  logic       frame_err;
  int         fe_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] b;
  logic [7:0] prev;

  assign rx = loop ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_txrx #(.CLOCKS_PER_PULSE(CPP)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_en   (data_en),
    .data_in   (data_in),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .rx        (rx),
    .ready_clr (ready_clr),
    .ready     (ready),
    .data_out  (data_out)
`ifdef UART_FRAME_ERR_EN
    ,
    .frame_err (frame_err)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
`ifdef UART_FRAME_ERR_EN
    if (frame_err === 1'b1) fe_cnt++;
`endif
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // line level i cycles into a frame carrying byte v
  function automatic logic line_bit(input logic [7:0] v, input int i);
    int k;
    k = i / CPP;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return v[k-1];
  endfunction

  task automatic send_frame(input logic [7:0] v);
    data_in = v;
    data_en = 1'b0;
    step;
    for (int i = 0; i < 10 * CPP; i++) begin
      chk("tx_bit", 32'(tx), 32'(line_bit(v, i)));
      chk("tx_busy", 32'(tx_busy), 32'd1);
      if (i == 4) data_en = 1'b1;
      if (i == 8) data_in = ~v;
      step;
    end
    chk("tx_idle_busy", 32'(tx_busy), 32'd0);
    chk("tx_idle_line", 32'(tx), 32'd1);
  endtask

  task automatic wait_ready(input logic [7:0] v);
    for (int k = 0; k < 20 && ready !== 1'b1; k++) step;
    chk("ready_set", 32'(ready), 32'd1);
    chk("data_out", 32'(data_out), 32'(v));
  endtask

  task automatic clear_ready;
    ready_clr = 1'b0;
    step;
    ready_clr = 1'b1;
    chk("ready_clr", 32'(ready), 32'd0);
  endtask

  task automatic drive_rx(input logic [7:0] v, input logic stop);
    for (int i = 0; i < 10 * CPP; i++) begin
      rx_drv = (i / CPP == 9) ? stop : line_bit(v, i);
      step;
    end
    rx_drv = 1'b1;
    repeat (3) step;
  endtask

  initial begin
    rst       = 1'b1;
    data_en   = 1'b1;
    data_in   = 8'h00;
    ready_clr = 1'b1;
    rx_drv    = 1'b1;
    loop      = 1'b1;
`ifdef UART_FRAME_ERR_EN
    fe_cnt    = 0;
`endif
    step;
    step;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    rst = 1'b0;
    step;

    send_frame(8'hAC);
    wait_ready(8'hAC);

    clear_ready;
    send_frame(8'h2B);
    wait_ready(8'h2B);

    for (int n = 0; n < 4; n++) begin
      b = 8'($urandom);
      clear_ready;
      send_frame(b);
      wait_ready(b);
    end

    // held request streams two frames back to back
    b = 8'($urandom);
    clear_ready;
    data_in = b;
    data_en = 1'b0;
    step;
    for (int i = 0; i < 20 * CPP; i++) begin
      chk("hold_tx", 32'(tx), 32'(line_bit(b, i % (10 * CPP))));
      chk("hold_busy", 32'(tx_busy), 32'd1);
      if (i == 45) data_in = ~b;
      if (i == 50) data_en = 1'b1;
      step;
    end
    chk("hold_end_busy", 32'(tx_busy), 32'd0);
    wait_ready(b);

    // one-cycle low pulse on rx is rejected as a glitch
    loop = 1'b0;
    rx_drv = 1'b1;
    clear_ready;
    prev = data_out;
    rx_drv = 1'b0;
    step;
    rx_drv = 1'b1;
    repeat (8) step;
    chk("glitch_ready", 32'(ready), 32'd0);
    chk("glitch_dout", 32'(data_out), 32'(prev));
    drive_rx(8'hA5, 1'b1);
    chk("rx_a5_ready", 32'(ready), 32'd1);
    chk("rx_a5_dout", 32'(data_out), 32'h0A5);

    // reset during data bit 3 of a loopback frame
    loop = 1'b1;
    b = 8'($urandom);
    data_in = b;
    data_en = 1'b0;
    step;
    data_en = 1'b1;
    repeat (18) step;
    chk("pre_rst_bit3", 32'(tx), 32'(b[3]));
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(tx_busy), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_dout", 32'(data_out), 32'd0);
    step;
    send_frame(8'h0F);
    wait_ready(8'h0F);

    // stop bit driven low
    loop = 1'b0;
    clear_ready;
    prev = data_out;
`ifdef UART_FRAME_ERR_EN
    fe_cnt = 0;
`endif
    drive_rx(8'h3C, 1'b0);
`ifdef UART_FRAME_ERR_EN
    chk("ferr_pulses", 32'(fe_cnt), 32'd1);
    chk("ferr_ready", 32'(ready), 32'd0);
    chk("ferr_dout", 32'(data_out), 32'(prev));
`else
    chk("bad_stop_ready", 32'(ready), 32'd1);
    chk("bad_stop_dout", 32'(data_out), 32'h03C);
`endif

    b = 8'($urandom);
    clear_ready;
    drive_rx(b, 1'b1);
    chk("rx_after_ready", 32'(ready), 32'd1);
    chk("rx_after_dout", 32'(data_out), 32'(b));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
